multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back. Drives the 2-bit `ALUctr` code into the downstream ALU-operation decoder plus all datapath enables, and stalls on a memory ready handshake. Also counts retired instructions and traps illegal opcodes.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_out_dec.sv | 78 +++++++
 rtl/multicycle_ctrl.sv | 102 ++++++++++
 tb/tb_multicycle_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTEXE,
    S_RTWB,
    S_BRANCH,
    S_JUMP,
    S_ORIEXE,
    S_ORIWB,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b001101;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_LOGI = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctr;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_out_dec.sv
// Moore decode of the FSM state into datapath controls; only the FETCH
// write enables look at mem_ready.
module mc_out_dec
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_ctr   = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_ctr   = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctr   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_RTEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_ctr   = ALU_FUNC;
      end
      S_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_ctr       = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ORIEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctr   = ALU_LOGI;
      end
      S_ORIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter and
// illegal-opcode trap.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUctr,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_RTEXE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ORI:       state_d = S_ORIEXE;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_RTEXE:  state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ORIEXE: state_d = S_ORIWB;
      S_ORIWB:  state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Only completing states ever return to FETCH, so any re-entry is a retire.
  always_comb begin
    retired_d = retired_q;
    if (state_q != S_FETCH && state_d == S_FETCH) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  mc_out_dec u_out_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign PCSource    = ctrl.pc_source;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUctr      = ctrl.alu_ctr;
  assign illegal     = ctrl.illegal;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences plus
// randomized instructions/stalls against an instruction-level phase model.
module tb_multicycle_ctrl;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [5:0]          op;
  logic                mem_ready;
  logic                PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic                MemtoReg, RegWrite, RegDst, ALUSrcA, illegal;
  logic [1:0]          PCSource, ALUSrcB, ALUctr;
  logic [TB_CNT_W-1:0] retired;
  logic [16:0]         obs;

  int checks  = 0;
  int errors  = 0;
  int exp_ret = 0;

  multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUctr(ALUctr), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB,
                ALUctr, illegal};

  // Expected control vector for one instruction phase, from the state table.
  // Phase letters: F fetch, D decode, A address, R mem read, M mem writeback,
  // W mem write, X R-exec, Y R-writeback, B branch, J jump, O ori-exec,
  // P ori-writeback, T trap.
  function automatic logic [16:0] exp_out(input byte ph, input logic rdy);
    logic [16:0] v;
    v = '0;
    case (ph)
      "F": begin v[13] = 1'b1; v[4:3] = 2'b01; v[11] = rdy; v[16] = rdy; end
      "D": v[4:3] = 2'b11;
      "A": begin v[7] = 1'b1; v[4:3] = 2'b10; end
      "R": begin v[13] = 1'b1; v[14] = 1'b1; end
      "M": begin v[9] = 1'b1; v[10] = 1'b1; end
      "W": begin v[12] = 1'b1; v[14] = 1'b1; end
      "X": begin v[7] = 1'b1; v[2:1] = 2'b10; end
      "Y": begin v[9] = 1'b1; v[8] = 1'b1; end
      "B": begin v[7] = 1'b1; v[2:1] = 2'b01; v[15] = 1'b1; v[6:5] = 2'b01; end
      "J": begin v[16] = 1'b1; v[6:5] = 2'b10; end
      "O": begin v[7] = 1'b1; v[4:3] = 2'b10; v[2:1] = 2'b11; end
      "P": v[9] = 1'b1;
      "T": v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic string phases(input logic [5:0] o);
    case (o)
      6'b100011: return "FDARM";
      6'b101011: return "FDAW";
      6'b000000: return "FDXY";
      6'b000100: return "FDB";
      6'b000010: return "FDJ";
      6'b001101: return "FDOP";
      default:   return "FDT";
    endcase
  endfunction

  task automatic check(input string tag, input logic [16:0] o, input logic [16:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_ret(input string tag);
    check(tag, 17'(retired), 17'(exp_ret % (1 << TB_CNT_W)));
  endtask

  task automatic cycle(input byte ph, input logic [5:0] opv, input logic rdy);
    @(negedge clk);
    op = opv;
    mem_ready = rdy;
    #1;
    check($sformatf("ctrl_%c", ph), obs, exp_out(ph, rdy));
    check_ret($sformatf("retired_%c", ph));
  endtask

  task automatic run_instr(input logic [5:0] opc, input int fst, input int mst);
    string ph;
    byte   p;
    int    n;
    logic  rdy;
    ph = phases(opc);
    for (int i = 0; i < ph.len(); i++) begin
      p = ph[i];
      n = (p == "F") ? fst : ((p == "R" || p == "W") ? mst : 0);
      for (int s = 0; s <= n; s++) begin
        rdy = (p == "F" || p == "R" || p == "W") ? (s == n) : 1'($urandom);
        cycle(p, (p == "D" || p == "A") ? opc : 6'($urandom), rdy);
      end
    end
    exp_ret++;
    $display("instr op=%b phases=%s fetch_stalls=%0d mem_stalls=%0d retired_model=%0d",
             opc, ph, fst, mst, exp_ret % (1 << TB_CNT_W));
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001101};

    rst = 1'b1;
    op = 6'd0;
    mem_ready = 1'b0;
    #12;
    check("reset_ctrl_nrdy", obs, exp_out("F", 1'b0));
    check_ret("reset_retired");
    mem_ready = 1'b1;
    #1;
    check("reset_ctrl_rdy", obs, exp_out("F", 1'b1));
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed: lw, R with 3 fetch stalls, beq + j back-to-back
    run_instr(6'b100011, 0, 0);
    run_instr(6'b000000, 3, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b101011, 1, 2);
    run_instr(6'b001101, 0, 0);

    // Random instruction mix with random stalls; counter wraps at 16
    for (int k = 0; k < 40; k++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Async reset while waiting in MEMWR
    if (exp_ret % (1 << TB_CNT_W) == 0) run_instr(6'b000010, 0, 0);
    cycle("F", 6'($urandom), 1'b1);
    cycle("D", 6'b101011, 1'($urandom));
    cycle("A", 6'b101011, 1'($urandom));
    cycle("W", 6'($urandom), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    exp_ret = 0;
    $display("async reset in MEMWR");
    check("memwr_rst_ctrl", obs, exp_out("F", 1'b0));
    check_ret("memwr_rst_retired");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // Illegal opcode: trap holds for 20 cycles regardless of inputs
    cycle("F", 6'($urandom), 1'b1);
    cycle("D", 6'b111111, 1'($urandom));
    for (int k = 0; k < 20; k++) begin
      cycle("T", 6'($urandom), 1'($urandom));
    end
    $display("trap op=111111 held 20 cycles retired_model=%0d", exp_ret % (1 << TB_CNT_W));
    #2;
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    exp_ret = 0;
    check("trap_rst_ctrl", obs, exp_out("F", 1'b0));
    check_ret("trap_rst_retired");
    @(negedge clk);
    rst = 1'b0;
    run_instr(6'b100011, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
